// File: rtl/game_flow_ctl_if.sv
// Purpose: button/engine inputs and reset/enable/status outputs of the game flow controller.
// Latency: none, wiring only.
// Backpressure: none; button levels and engine pulses are sampled every clock.
interface game_flow_ctl_if #(
  parameter int LEVEL_W = 13,
  parameter int LIVES_W = 2
);
  logic               ok;
  logic               pause;
  logic               next_lvl;
  logic               fail;
  logic               game_reset;
  logic               game_ctl_reset;
  logic               text_reset;
  logic               game_freeze;
  logic [2:0]         game_state;
  logic [LEVEL_W-1:0] level;
  logic [LIVES_W-1:0] lives;

  // Controller side: consumes buttons/engine events, drives strobes and status.
  modport master (
    input  ok, pause, next_lvl, fail,
    output game_reset, game_ctl_reset, text_reset, game_freeze,
    output game_state, level, lives
  );

  // Stimulus/peripheral side: drives buttons/engine events, observes strobes.
  modport slave (
    output ok, pause, next_lvl, fail,
    input  game_reset, game_ctl_reset, text_reset, game_freeze,
    input  game_state, level, lives
  );
endinterface

// File: rtl/game_flow_ctl.sv
// Purpose: game flow FSM with levels, lives, pause and a message-hold window before ok is accepted.
// Latency: outputs are registered and decoded from the next state, so they change on the same edge as game_state.
// Backpressure: none; ok/pause are edge-detected, next_lvl/fail are only honoured in GAME.
module game_flow_ctl #(
  parameter int LEVEL_W   = 13,
  parameter int MAX_LEVEL = 4,
  parameter int LIVES     = 3,
  parameter int LIVES_W   = 2,
  parameter int MSG_TICKS = 16,
  parameter int CNT_W     = 5
) (
  input  logic           clk,
  input  logic           rst,
  game_flow_ctl_if.master bus
);

  typedef enum logic [2:0] {
    S_START      = 3'd0,
    S_NEXT_LEVEL = 3'd1,
    S_FAIL       = 3'd2,
    S_FINISH     = 3'd3,
    S_GAME       = 3'd4,
    S_PAUSE      = 3'd5,
    S_GAME_OVER  = 3'd6
  } state_t;

  state_t             r_state;
  logic [LEVEL_W-1:0] r_level;
  logic [LIVES_W-1:0] r_lives;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic               r_ok_d;
  logic               r_pause_d;
  logic               r_game_reset;
  logic               r_game_ctl_reset;
  logic               r_text_reset;
  logic               r_game_freeze;

  state_t             w_next_state;
  logic [LEVEL_W-1:0] w_next_level;
  logic [LIVES_W-1:0] w_next_lives;
  logic               w_ok_rise;
  logic               w_pause_rise;
  logic               w_hold_done;
  logic               w_ok_acc;
  logic               w_game_reset;
  logic               w_game_ctl_reset;
  logic               w_text_reset;
  logic               w_game_freeze;

  // Delayed copies reset to 1 so a button held through reset needs a release first.
  assign w_ok_rise    = bus.ok & ~r_ok_d;
  assign w_pause_rise = bus.pause & ~r_pause_d;
  assign w_hold_done  = (r_hold_cnt == CNT_W'(MSG_TICKS - 1));
  assign w_ok_acc     = w_ok_rise & w_hold_done;

  // Next state plus level/lives updates; fail beats next_lvl beats pause in GAME.
  always_comb begin
    w_next_state = r_state;
    w_next_level = r_level;
    w_next_lives = r_lives;
    case (r_state)
      S_START: begin
        if (w_ok_acc) begin
          w_next_state = S_GAME;
          w_next_level = LEVEL_W'(1);
          w_next_lives = LIVES_W'(LIVES);
        end
      end
      S_GAME: begin
        if (bus.fail) begin
          if (r_lives == LIVES_W'(1)) begin
            w_next_state = S_GAME_OVER;
            w_next_lives = '0;
          end else begin
            w_next_state = S_FAIL;
            w_next_lives = r_lives - LIVES_W'(1);
          end
        end else if (bus.next_lvl) begin
          if (r_level == LEVEL_W'(MAX_LEVEL)) begin
            w_next_state = S_FINISH;
          end else begin
            w_next_state = S_NEXT_LEVEL;
            w_next_level = r_level + LEVEL_W'(1);
          end
        end else if (w_pause_rise) begin
          w_next_state = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (w_pause_rise || w_ok_rise) w_next_state = S_GAME;
      end
      S_NEXT_LEVEL, S_FAIL: begin
        if (w_ok_acc) w_next_state = S_GAME;
      end
      S_FINISH, S_GAME_OVER: begin
        if (w_ok_acc) w_next_state = S_START;
      end
      default: w_next_state = S_START;
    endcase
  end

  // Decode strobes from the next state so they register alongside it.
  always_comb begin
    w_game_ctl_reset = 1'b0;
    w_game_reset     = 1'b1;
    w_text_reset     = 1'b0;
    w_game_freeze    = 1'b0;
    case (w_next_state)
      S_START: begin
        w_game_ctl_reset = 1'b1;
        w_game_reset     = 1'b1;
      end
      S_GAME: begin
        w_game_reset = 1'b0;
        w_text_reset = 1'b1;
      end
      S_PAUSE: begin
        w_game_reset  = 1'b0;
        w_text_reset  = 1'b1;
        w_game_freeze = 1'b1;
      end
      default: ;
    endcase
  end

  // State, level, lives, edge-detect history and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_START;
      r_level          <= LEVEL_W'(1);
      r_lives          <= LIVES_W'(LIVES);
      r_ok_d           <= 1'b1;
      r_pause_d        <= 1'b1;
      r_game_reset     <= 1'b1;
      r_game_ctl_reset <= 1'b1;
      r_text_reset     <= 1'b1;
      r_game_freeze    <= 1'b0;
    end else begin
      r_state          <= w_next_state;
      r_level          <= w_next_level;
      r_lives          <= w_next_lives;
      r_ok_d           <= bus.ok;
      r_pause_d        <= bus.pause;
      r_game_reset     <= w_game_reset;
      r_game_ctl_reset <= w_game_ctl_reset;
      r_text_reset     <= w_text_reset;
      r_game_freeze    <= w_game_freeze;
    end
  end

  // Message-hold timer: restarts on every state change, saturates once the window has elapsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_hold_cnt <= '0;
    end else if (!w_hold_done) begin
      r_hold_cnt <= r_hold_cnt + CNT_W'(1);
    end
  end

  assign bus.game_state     = r_state;
  assign bus.level          = r_level;
  assign bus.lives          = r_lives;
  assign bus.game_reset     = r_game_reset;
  assign bus.game_ctl_reset = r_game_ctl_reset;
  assign bus.text_reset     = r_text_reset;
  assign bus.game_freeze    = r_game_freeze;

endmodule

// File: tb/tb_game_flow_ctl.sv
// Purpose: self-checking bench for game_flow_ctl with MSG_TICKS=4, LIVES=2, MAX_LEVEL=3.
// Latency: one expected record per clock, compared 1 time unit after the rising edge.
// Backpressure: none; stimulus is a per-cycle vector table plus hand-written sequences.
module tb_game_flow_ctl;
  localparam int LEVEL_W   = 13;
  localparam int MAX_LEVEL = 3;
  localparam int LIVES     = 2;
  localparam int LIVES_W   = 2;
  localparam int MSG_TICKS = 4;
  localparam int CNT_W     = 5;

  // Outputs packed as {game_ctl_reset, game_reset, text_reset, game_freeze}.
  localparam logic [3:0] O_START = 4'b1100;
  localparam logic [3:0] O_GAME  = 4'b0010;
  localparam logic [3:0] O_PAUSE = 4'b0011;
  localparam logic [3:0] O_MSG   = 4'b0100;
  localparam logic [3:0] O_RST   = 4'b1110;

  typedef struct {
    logic               ok;
    logic               pa;
    logic               nl;
    logic               fl;
    logic [2:0]         st;
    logic [LEVEL_W-1:0] lvl;
    logic [LIVES_W-1:0] lv;
    logic [3:0]         outs;
  } vec_t;

  typedef struct {
    logic [2:0]         st;
    logic [LEVEL_W-1:0] lvl;
    logic [LIVES_W-1:0] lv;
    logic [3:0]         outs;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  game_flow_ctl_if #(.LEVEL_W(LEVEL_W), .LIVES_W(LIVES_W)) bus ();

  game_flow_ctl #(
    .LEVEL_W(LEVEL_W), .MAX_LEVEL(MAX_LEVEL), .LIVES(LIVES),
    .LIVES_W(LIVES_W), .MSG_TICKS(MSG_TICKS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic check_out(input string tag);
    exp_t e;
    logic [3:0] o;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    o = {bus.game_ctl_reset, bus.game_reset, bus.text_reset, bus.game_freeze};
    chk({tag, " state"}, 32'(bus.game_state), 32'(e.st));
    chk({tag, " level"}, 32'(bus.level), 32'(e.lvl));
    chk({tag, " lives"}, 32'(bus.lives), 32'(e.lv));
    chk({tag, " outs"},  32'(o), 32'(e.outs));
  endtask

  task automatic push_exp(input int st, input int lvl, input int lv, input logic [3:0] o);
    exp_t e;
    e.st = 3'(st); e.lvl = LEVEL_W'(lvl); e.lv = LIVES_W'(lv); e.outs = o;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, record its expectation, then compare after the edge.
  task automatic apply(input logic ok, input logic pa, input logic nl, input logic fl,
                       input int st, input int lvl, input int lv, input logic [3:0] o,
                       input string tag);
    bus.ok = ok; bus.pause = pa; bus.next_lvl = nl; bus.fail = fl;
    push_exp(st, lvl, lv, o);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic add(input logic ok, input logic pa, input logic nl, input logic fl,
                     input int st, input int lvl, input int lv, input logic [3:0] o,
                     input int n);
    vec_t v;
    v.ok = ok; v.pa = pa; v.nl = nl; v.fl = fl;
    v.st = 3'(st); v.lvl = LEVEL_W'(lvl); v.lv = LIVES_W'(lv); v.outs = o;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ok held high through reset must not start the game.
    add(1,0,0,0, 0,1,2,O_START, 10);
    add(0,0,0,0, 0,1,2,O_START, 4);
    add(1,0,0,0, 4,1,2,O_GAME,  1);
    // Level 1 -> NEXT_LEVEL; early ok rejected, ok after the hold accepted.
    add(0,0,0,0, 4,1,2,O_GAME,  1);
    add(0,0,1,0, 1,2,2,O_MSG,   1);
    add(1,0,0,0, 1,2,2,O_MSG,   1);
    add(0,0,0,0, 1,2,2,O_MSG,   2);
    add(1,0,0,0, 4,2,2,O_GAME,  1);
    // Level 2 -> 3, then last level -> FINISH -> START.
    add(0,0,0,0, 4,2,2,O_GAME,  1);
    add(0,0,1,0, 1,3,2,O_MSG,   1);
    add(0,0,0,0, 1,3,2,O_MSG,   3);
    add(1,0,0,0, 4,3,2,O_GAME,  1);
    add(0,0,0,0, 4,3,2,O_GAME,  1);
    add(0,0,1,0, 3,3,2,O_MSG,   1);
    add(0,0,0,0, 3,3,2,O_MSG,   3);
    add(1,0,0,0, 0,3,2,O_START, 1);
    // New game reloads level and lives; lose both lives.
    add(0,0,0,0, 0,3,2,O_START, 3);
    add(1,0,0,0, 4,1,2,O_GAME,  1);
    add(0,0,0,0, 4,1,2,O_GAME,  1);
    add(0,0,0,1, 2,1,1,O_MSG,   1);
    add(0,0,0,0, 2,1,1,O_MSG,   3);
    add(1,0,0,0, 4,1,1,O_GAME,  1);
    add(0,0,0,0, 4,1,1,O_GAME,  1);
    add(0,0,0,1, 6,1,0,O_MSG,   1);
    add(0,0,0,0, 6,1,0,O_MSG,   3);
    add(1,0,0,0, 0,1,0,O_START, 1);
    add(0,0,0,0, 0,1,0,O_START, 3);
    add(1,0,0,0, 4,1,2,O_GAME,  1);
    // fail and next_lvl together: fail wins; both ignored outside GAME.
    add(0,0,0,0, 4,1,2,O_GAME,  1);
    add(0,0,1,1, 2,1,1,O_MSG,   1);
    add(0,0,1,1, 2,1,1,O_MSG,   1);
    add(0,0,0,0, 2,1,1,O_MSG,   2);
    add(1,0,0,0, 4,1,1,O_GAME,  1);

    rst = 1'b1;
    bus.ok = 1'b1; bus.pause = 1'b0; bus.next_lvl = 1'b0; bus.fail = 1'b0;
    #12;
    push_exp(0, 1, 2, O_RST);
    check_out("reset");
    #1 rst = 1'b0;

    foreach (vecs[i])
      apply(vecs[i].ok, vecs[i].pa, vecs[i].nl, vecs[i].fl,
            int'(vecs[i].st), int'(vecs[i].lvl), int'(vecs[i].lv), vecs[i].outs,
            $sformatf("vec%0d", i));

    // Pause: freeze, engine events ignored, resume by pause or ok without hold.
    apply(0,0,0,0, 4,1,1,O_GAME,  "pause0");
    apply(0,1,0,0, 5,1,1,O_PAUSE, "pause_enter");
    apply(0,0,0,1, 5,1,1,O_PAUSE, "pause_fail");
    apply(0,0,1,0, 5,1,1,O_PAUSE, "pause_nl");
    apply(0,1,0,0, 4,1,1,O_GAME,  "pause_exit");
    apply(0,0,0,0, 4,1,1,O_GAME,  "pause1");
    apply(0,1,0,0, 5,1,1,O_PAUSE, "pause_enter2");
    apply(1,0,0,0, 4,1,1,O_GAME,  "pause_ok_exit");
    apply(0,0,0,0, 4,1,1,O_GAME,  "pause2");

    // Asynchronous reset mid-GAME, visible before the next clock edge.
    @(posedge clk);
    #3;
    bus.ok = 1'b1;
    rst = 1'b1;
    #1;
    push_exp(0, 1, 2, O_RST);
    check_out("async_rst");
    #2 rst = 1'b0;
    apply(1,0,0,0, 0,1,2,O_START, "post_rst_hold");
    apply(1,0,0,0, 0,1,2,O_START, "post_rst_hold");
    apply(0,0,0,0, 0,1,2,O_START, "post_rst_rel");
    apply(1,0,0,0, 4,1,2,O_GAME,  "post_rst_go");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
